// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: opcode, state and offset definitions shared by the fetch sequencer.
// Revision: 1.0
`default_nettype none

package fetch_seq_pkg;

    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_BZ   = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OFFSET_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        STEP   = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_timeout_timer.sv
// seq_timeout_timer: counts enabled wait cycles; expired flags the TIMEOUT-th one.
// Revision: 1.0
`default_nettype none

module seq_timeout_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // count holds the number of wait cycles already completed, so the
    // TIMEOUT-th wait cycle is the one where count == TIMEOUT-1
    assign expired = enable && (count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute control FSM driving the PC step and ALU handshake.
// Revision: 1.0
`default_nettype none

module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [7:0]    instr,
    input  logic          zero_flag,
    output logic          alu_start,
    output logic [5:0]    alu_op,
    input  logic          alu_done,
    output logic          pc_step,
    output logic          branch,
    output logic [AW-1:0] jump_value,
    output logic          busy,
    output logic          halted,
    output logic          error
);

    state_t               state;
    state_t               next_state;
    logic [7:0]           instr_q;
    logic                 branch_q;
    logic                 next_branch;
    logic                 exec_first;
    logic                 expired;
    logic [OFFSET_W-1:0]  offset;

    assign offset = instr_q[OFFSET_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            instr_q    <= 8'h00;
            branch_q   <= 1'b0;
            exec_first <= 1'b0;
        end else begin
            state      <= next_state;
            branch_q   <= next_branch;
            exec_first <= (state == DECODE) && (next_state == EXEC);
            if (state == FETCH && imem_ack) begin
                instr_q <= instr;
            end
        end
    end

    always_comb begin
        next_state  = state;
        next_branch = branch_q;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                if (imem_ack) next_state = DECODE;
            end
            DECODE: begin
                case (instr_q[7:6])
                    OP_ALU: begin
                        next_branch = 1'b0;
                        next_state  = (offset == '0) ? STEP : EXEC;
                    end
                    OP_BZ: begin
                        next_branch = zero_flag;
                        next_state  = STEP;
                    end
                    OP_JMP: begin
                        next_branch = 1'b1;
                        next_state  = STEP;
                    end
                    default: next_state = HALT;
                endcase
            end
            EXEC: begin
                // alu_done coinciding with alu_start is ignored; on the
                // final wait cycle completion takes priority over timeout
                if (!exec_first) begin
                    if (alu_done) begin
                        next_branch = 1'b0;
                        next_state  = STEP;
                    end else if (expired) begin
                        next_state = ERROR;
                    end
                end
            end
            STEP:    next_state = FETCH;
            HALT:    next_state = HALT;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase
    end

    seq_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != EXEC) || exec_first),
        .enable  ((state == EXEC) && !exec_first),
        .expired (expired)
    );

    assign imem_req   = (state == FETCH);
    assign alu_start  = exec_first;
    assign alu_op     = instr_q[5:0];
    assign pc_step    = (state == STEP);
    assign branch     = (state == STEP) && branch_q;
    assign jump_value = (state == STEP) ? {{(AW-OFFSET_W){offset[OFFSET_W-1]}}, offset} : '0;
    assign busy       = (state != IDLE) && (state != HALT) && (state != ERROR);
    assign halted     = (state == HALT);
    assign error      = (state == ERROR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks plus a pc_step scoreboard for fetch_sequencer.
// Revision: 1.0
`default_nettype none

module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       imem_req;
    logic       imem_ack = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       zero_flag = 1'b0;
    logic       alu_start;
    logic [5:0] alu_op;
    logic       alu_done = 1'b0;
    logic       pc_step;
    logic       branch;
    logic [7:0] jump_value;
    logic       busy;
    logic       halted;
    logic       error;

    typedef struct packed {
        logic       br;
        logic [7:0] jv;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   alu_starts = 0;

    fetch_sequencer #(.AW(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .zero_flag  (zero_flag),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .pc_step    (pc_step),
        .branch     (branch),
        .jump_value (jump_value),
        .busy       (busy),
        .halted     (halted),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Every pc_step pulse must match the next queued expectation
    always @(negedge clk) begin
        if (reset && alu_start) alu_starts++;
        if (reset && pc_step) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL pc_step_unexpected: got branch=%0b jump_value=%02h, required no pulse", branch, jump_value);
            end else begin
                e = sb.pop_front();
                if (branch !== e.br || jump_value !== e.jv) begin
                    failed++;
                    $display("FAIL pc_step_payload: got branch=%0b jump_value=%02h, required branch=%0b jump_value=%02h",
                             branch, jump_value, e.br, e.jv);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives one instruction fetch; returns with the DUT in DECODE
    task automatic fetch(input logic [7:0] v, input int waits);
        for (int i = 0; i < waits; i++) begin
            instr = 8'hC0;
            tick();
        end
        imem_ack = 1'b1;
        instr    = v;
        tick();
        imem_ack = 1'b0;
        instr    = 8'hFF;
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        #1;
        outs = {imem_req, alu_start, alu_op, pc_step, branch, jump_value, busy, halted, error};
        tests++;
        if (outs !== 24'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %06h, required 000000", outs);
        end
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        fetch(8'h0A, 0);
        tick();
        tests++;
        if (alu_start !== 1'b1) begin
            failed++;
            $display("FAIL reset_reach_exec: got alu_start=%0b, required 1", alu_start);
        end
        #2 reset = 1'b0;
        #1;
        outs = {imem_req, alu_start, alu_op, pc_step, branch, jump_value, busy, halted, error};
        tests++;
        if (outs !== 24'h0) begin
            failed++;
            $display("FAIL reset_async_abort: got %06h, required 000000", outs);
        end
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        tests++;
        if (imem_req !== 1'b1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL reset_restart: got imem_req=%0b busy=%0b, required 1 1", imem_req, busy);
        end
    endtask

    task automatic test_nop();
        sb.push_back('{br: 1'b0, jv: 8'h00});
        fetch(8'h00, 2);
        tick();
        tests++;
        if (pc_step !== 1'b1 || branch !== 1'b0 || imem_req !== 1'b0) begin
            failed++;
            $display("FAIL nop_step: got pc_step=%0b branch=%0b imem_req=%0b, required 1 0 0", pc_step, branch, imem_req);
        end
        tick();
        tests++;
        if (pc_step !== 1'b0 || imem_req !== 1'b1) begin
            failed++;
            $display("FAIL nop_refetch: got pc_step=%0b imem_req=%0b, required 0 1", pc_step, imem_req);
        end
    endtask

    task automatic test_bz();
        zero_flag = 1'b1;
        sb.push_back('{br: 1'b1, jv: 8'hFF});
        fetch(8'h7F, 0);
        tick();
        tests++;
        if (branch !== 1'b1 || jump_value !== 8'hFF) begin
            failed++;
            $display("FAIL bz_taken: got branch=%0b jump_value=%02h, required 1 ff", branch, jump_value);
        end
        tick();
        zero_flag = 1'b0;
        sb.push_back('{br: 1'b0, jv: 8'hFF});
        fetch(8'h7F, 1);
        tick();
        tests++;
        if (pc_step !== 1'b1 || branch !== 1'b0) begin
            failed++;
            $display("FAIL bz_not_taken: got pc_step=%0b branch=%0b, required 1 0", pc_step, branch);
        end
        tick();
    endtask

    task automatic test_jmp();
        logic [7:0] pc;
        logic [7:0] next_pc;
        pc = 8'h10;
        sb.push_back('{br: 1'b1, jv: 8'h05});
        fetch(8'h85, 0);
        tick();
        next_pc = branch ? pc + jump_value + 8'd1 : pc + 8'd1;
        tests++;
        if (next_pc !== 8'h16) begin
            failed++;
            $display("FAIL jmp_next_pc: got %02h, required 16", next_pc);
        end
        tick();
    endtask

    task automatic test_alu();
        int starts0;
        starts0 = alu_starts;
        sb.push_back('{br: 1'b0, jv: 8'h0A});
        fetch(8'h0A, 0);
        tick();
        tests++;
        if (alu_start !== 1'b1 || alu_op !== 6'h0A || pc_step !== 1'b0) begin
            failed++;
            $display("FAIL alu_launch: got alu_start=%0b alu_op=%02h pc_step=%0b, required 1 0a 0", alu_start, alu_op, pc_step);
        end
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tests++;
        if (alu_start !== 1'b0 || pc_step !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL alu_done_in_start_ignored: got alu_start=%0b pc_step=%0b busy=%0b, required 0 0 1", alu_start, pc_step, busy);
        end
        tick();
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tests++;
        if (pc_step !== 1'b1 || alu_starts - starts0 !== 1) begin
            failed++;
            $display("FAIL alu_complete: got pc_step=%0b alu_starts=%0d, required 1 1", pc_step, alu_starts - starts0);
        end
        tick();
    endtask

    task automatic test_done_on_timeout_cycle();
        sb.push_back('{br: 1'b0, jv: 8'h0A});
        fetch(8'h0A, 0);
        tick();
        for (int i = 0; i < 16; i++) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tests++;
        if (pc_step !== 1'b1 || error !== 1'b0) begin
            failed++;
            $display("FAIL done_wins_timeout: got pc_step=%0b error=%0b, required 1 0", pc_step, error);
        end
        tick();
    endtask

    task automatic test_timeout();
        fetch(8'h0A, 0);
        tick();
        for (int i = 0; i < 16; i++) tick();
        tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL timeout_early: got error=%0b busy=%0b after 15 waits, required 0 1", error, busy);
        end
        tick();
        tests++;
        if (error !== 1'b1 || busy !== 1'b0 || pc_step !== 1'b0) begin
            failed++;
            $display("FAIL timeout_error: got error=%0b busy=%0b pc_step=%0b, required 1 0 0", error, busy, pc_step);
        end
        pulse_start();
        tick();
        tests++;
        if (error !== 1'b1 || imem_req !== 1'b0) begin
            failed++;
            $display("FAIL error_terminal: got error=%0b imem_req=%0b, required 1 0", error, imem_req);
        end
    endtask

    task automatic test_halt();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        fetch(8'hC0, 1);
        tick();
        tests++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc_step !== 1'b0) begin
            failed++;
            $display("FAIL halt_enter: got halted=%0b busy=%0b pc_step=%0b, required 1 0 0", halted, busy, pc_step);
        end
        pulse_start();
        tick();
        tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL halt_terminal: got halted=%0b imem_req=%0b busy=%0b, required 1 0 0", halted, imem_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_bz();
        test_jmp();
        test_alu();
        test_done_on_timeout_cycle();
        test_timeout();
        test_halt();
        tick();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL pc_step_missing: got %0d outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
